heap_arbiter: RTL

Shares the single heap `Memory` instance between several requesters inside `fpga`. It grants one request at a time in round-robin order and presents the granted action and operands on the heap bus. It then strobes the heap clock by toggling it once, waits a fixed settle time, and returns the heap result to the winner with a one-cycle acknowledge. It replaces the open-coded `heapClock`/`heapAction` assignments scattered through the instruction `case`.

---
 rtl/heap_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/heap_arbiter.sv
// rtl/heap_arbiter.sv - round-robin arbiter sharing the heap Memory between requesters
// Sequences one heap transaction at a time: latch operands, strobe heapClock once, settle, acknowledge.
module heap_arbiter #(
   parameter int REQUESTERS = 4,
   parameter int WIDTH      = 12,
   parameter int SETTLE     = 2
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [REQUESTERS-1:0]       req,
   input  logic [8*REQUESTERS-1:0]     reqAction,
   input  logic [WIDTH*REQUESTERS-1:0] reqArray,
   input  logic [WIDTH*REQUESTERS-1:0] reqIndex,
   input  logic [WIDTH*REQUESTERS-1:0] reqData,
   output logic [REQUESTERS-1:0]       ack,
   output logic [WIDTH-1:0]            ackData,
   output logic                        busy,
   output logic                        heapClock,
   output logic [7:0]                  heapAction,
   output logic [WIDTH-1:0]            heapArray,
   output logic [WIDTH-1:0]            heapIndex,
   output logic [WIDTH-1:0]            heapIn,
   input  logic [WIDTH-1:0]            heapOut
);

   localparam int IW = $clog2(REQUESTERS);

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_SETTLE, S_ACK} state_t;

   state_t          state;
   logic [IW-1:0]   rr_ptr;
   logic [IW-1:0]   grant;
   logic [3:0]      cnt;
   logic            reset_d;
   logic [IW-1:0]   pick;
   logic            found;
   logic [7:0]      sel_action;
   logic [WIDTH-1:0] sel_array;
   logic [WIDTH-1:0] sel_index;
   logic [WIDTH-1:0] sel_data;

   // First set request at or above rr_ptr, wrapping around.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      for (int k = 0; k < REQUESTERS; k++) begin
         for (int i = 0; i < REQUESTERS; i++) begin
            if (!found && req[i] && (((int'(rr_ptr) + k) % REQUESTERS) == i)) begin
               found = 1'b1;
               pick  = IW'(i);
            end
         end
      end
   end

   always_comb begin
      sel_action = '0;
      sel_array  = '0;
      sel_index  = '0;
      sel_data   = '0;
      for (int i = 0; i < REQUESTERS; i++) begin
         if (pick == IW'(i)) begin
            sel_action = reqAction[i*8 +: 8];
            sel_array  = reqArray[i*WIDTH +: WIDTH];
            sel_index  = reqIndex[i*WIDTH +: WIDTH];
            sel_data   = reqData[i*WIDTH +: WIDTH];
         end
      end
   end

   always_ff @(posedge clock) begin
      reset_d <= reset;
      if (reset) begin
         state      <= S_IDLE;
         rr_ptr     <= '0;
         grant      <= '0;
         cnt        <= '0;
         ack        <= '0;
         ackData    <= '0;
         busy       <= 1'b0;
         heapAction <= '0;
         heapArray  <= '0;
         heapIndex  <= '0;
         heapIn     <= '0;
         // Clearing only on the second reset cycle keeps any falling strobe paired with a no-op action.
         if (reset_d) heapClock <= 1'b0;
      end else begin
         ack <= '0;
         case (state)
            S_IDLE: begin
               if (found) begin
                  grant      <= pick;
                  heapAction <= sel_action;
                  heapArray  <= sel_array;
                  heapIndex  <= sel_index;
                  heapIn     <= sel_data;
                  busy       <= 1'b1;
                  state      <= S_SETUP;
               end
            end
            S_SETUP: state <= S_STROBE;
            S_STROBE: begin
               heapClock <= ~heapClock;
               cnt       <= 4'(SETTLE - 1);
               state     <= S_SETTLE;
            end
            S_SETTLE: begin
               if (cnt == 4'd0) begin
                  ackData <= heapOut;
                  state   <= S_ACK;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            S_ACK: begin
               ack        <= REQUESTERS'(1) << grant;
               rr_ptr     <= (grant == IW'(REQUESTERS - 1)) ? '0 : grant + 1'b1;
               heapAction <= '0;
               busy       <= 1'b0;
               state      <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
